// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped, read-only instruction cache holding one 32-bit
//            word per line. It sits between the instruction fetcher and the
//            memory controller's IC port.
// Revision : 1.0 - initial release
// ============================================================================
module icache #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              IF_valid,
  input  logic [ADDR_W-1:0] IF_addr,
  input  logic              clear,
  output logic              IF_ready,
  output logic [31:0]       IF_inst,
  output logic              IC_rn,
  output logic [ADDR_W-1:0] IC_addr,
  input  logic              IC_ready,
  input  logic [31:0]       IC_value
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t state;

  // Line storage. Only the valid bits are reset; tag and data are meaningless
  // until their valid bit is set.
  logic [LINES-1:0] line_valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // Set once IC_ready has been seen low during the current miss. A level
  // IC_ready left high by the previous transfer is not taken as completion.
  logic seen_low;
  // A clear arrived while a miss was outstanding: fill the line but do not
  // hand the word to the fetcher.
  logic drop;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  req_hit;
  logic                  accept;
  logic                  fill_fire;
  logic                  unused_offset;

  assign req_idx   = IF_addr[INDEX_BITS+1:2];
  assign req_tag   = IF_addr[ADDR_W-1:INDEX_BITS+2];
  // IC_addr carries the latched request for the whole miss, so it also
  // provides the fill location.
  assign fill_idx  = IC_addr[INDEX_BITS+1:2];
  assign fill_tag  = IC_addr[ADDR_W-1:INDEX_BITS+2];
  assign req_hit   = line_valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept    = (state == IDLE) && IF_valid && !clear;
  assign fill_fire = (state == MISS) && IC_ready && seen_low;
  // The byte offset within the word is not needed.
  assign unused_offset = ^IF_addr[1:0];

  // Array write on the completing edge. Reset suppresses it, so a miss that
  // is aborted by reset leaves no trace in the array.
  always_ff @(posedge clk) begin
    if (rdy && !rst && fill_fire) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= IC_value;
    end
  end

  // Control FSM with registered outputs. rdy low freezes every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      line_valid <= '0;
      seen_low   <= 1'b0;
      drop       <= 1'b0;
      IF_ready   <= 1'b0;
      IF_inst    <= 32'h0;
      IC_rn      <= 1'b0;
      IC_addr    <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          // Default: no response. This also drops a hit response when clear
          // blocks acceptance.
          IF_ready <= 1'b0;
          if (accept) begin
            if (req_hit) begin
              IF_ready <= 1'b1;
              IF_inst  <= data_mem[req_idx];
            end else begin
              state    <= MISS;
              IC_rn    <= 1'b1;
              IC_addr  <= {IF_addr[ADDR_W-1:2], 2'b00};
              seen_low <= 1'b0;
              drop     <= 1'b0;
            end
          end
        end
        MISS: begin
          if (!IC_ready) begin
            seen_low <= 1'b1;
          end
          if (fill_fire) begin
            line_valid[fill_idx] <= 1'b1;
            IC_rn    <= 1'b0;
            IF_inst  <= IC_value;
            IF_ready <= !(drop || clear);
            drop     <= 1'b0;
            state    <= IDLE;
          end else if (clear) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache
// Purpose  : Directed self-checking bench for icache, with the memory
//            controller's responses driven by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        IF_valid;
  logic [31:0] IF_addr;
  logic        clear;
  logic        IF_ready;
  logic [31:0] IF_inst;
  logic        IC_rn;
  logic [31:0] IC_addr;
  logic        IC_ready;
  logic [31:0] IC_value;

  int n_checks = 0;
  int n_fail   = 0;

  icache #(.INDEX_BITS(6), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .IF_valid (IF_valid),
    .IF_addr  (IF_addr),
    .clear    (clear),
    .IF_ready (IF_ready),
    .IF_inst  (IF_inst),
    .IC_rn    (IC_rn),
    .IC_addr  (IC_addr),
    .IC_ready (IC_ready),
    .IC_value (IC_value)
  );

  always #5 clk = ~clk;

  // Advance one clock. Inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a one-cycle request, then move IF_addr to junk. This shows that
  // the cache works from the latched address.
  task automatic req(input logic [31:0] a);
    IF_valid = 1'b1;
    IF_addr  = a;
    tick();
    IF_valid = 1'b0;
    IF_addr  = 32'hFFFF_FFFC;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; IF_valid = 1'b0; IF_addr = '0; clear = 1'b0;
    IC_ready = 1'b0; IC_value = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_if_ready", {31'b0, IF_ready}, 32'd0);
    chk("rst_if_inst", IF_inst, 32'h0);
    chk("rst_ic_rn", {31'b0, IC_rn}, 32'd0);
    chk("rst_ic_addr", IC_addr, 32'h0);

    // Cold miss at 0x1004.
    req(32'h0000_1004);
    chk("cold_rn", {31'b0, IC_rn}, 32'd1);
    chk("cold_addr", IC_addr, 32'h0000_1004);
    chk("cold_no_ready", {31'b0, IF_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cold_hold_rn", {31'b0, IC_rn}, 32'd1);
      chk("cold_hold_addr", IC_addr, 32'h0000_1004);
      chk("cold_wait_ready", {31'b0, IF_ready}, 32'd0);
    end
    IC_ready = 1'b1; IC_value = 32'hDEAD_BEEF;
    tick();
    chk("cold_ready", {31'b0, IF_ready}, 32'd1);
    chk("cold_inst", IF_inst, 32'hDEAD_BEEF);
    chk("cold_rn_done", {31'b0, IC_rn}, 32'd0);
    tick();
    chk("cold_pulse_end", {31'b0, IF_ready}, 32'd0);
    chk("cold_inst_hold", IF_inst, 32'hDEAD_BEEF);

    // Hit on the same word. The byte offset is ignored, and IC_ready is
    // still high.
    req(32'h0000_1006);
    chk("hit_ready", {31'b0, IF_ready}, 32'd1);
    chk("hit_inst", IF_inst, 32'hDEAD_BEEF);
    chk("hit_rn", {31'b0, IC_rn}, 32'd0);
    tick();
    chk("hit_pulse_end", {31'b0, IF_ready}, 32'd0);

    // Conflict miss at 0x1104. IC_ready is still high and carries the stale
    // value, so it must not be taken until it has been seen low.
    req(32'h0000_1104);
    chk("conf_rn", {31'b0, IC_rn}, 32'd1);
    chk("conf_addr", IC_addr, 32'h0000_1104);
    tick();
    chk("stale_no_ready1", {31'b0, IF_ready}, 32'd0);
    chk("stale_rn1", {31'b0, IC_rn}, 32'd1);
    tick();
    chk("stale_no_ready2", {31'b0, IF_ready}, 32'd0);
    IC_ready = 1'b0;
    tick();
    chk("stale_low_rn", {31'b0, IC_rn}, 32'd1);
    IC_ready = 1'b1; IC_value = 32'h1234_5678;
    tick();
    chk("stale_ready", {31'b0, IF_ready}, 32'd1);
    chk("stale_inst", IF_inst, 32'h1234_5678);

    // 0x1004 was evicted, so it misses again. IC_ready is still high.
    req(32'h0000_1004);
    chk("evict_rn", {31'b0, IC_rn}, 32'd1);
    chk("evict_addr", IC_addr, 32'h0000_1004);
    chk("evict_no_ready", {31'b0, IF_ready}, 32'd0);
    IC_ready = 1'b0;
    tick();
    IC_ready = 1'b1; IC_value = 32'hDEAD_BEEF;
    tick();
    chk("evict_ready", {31'b0, IF_ready}, 32'd1);
    chk("evict_inst", IF_inst, 32'hDEAD_BEEF);
    IC_ready = 1'b0;

    // Back-to-back hits deliver one word per cycle.
    IF_valid = 1'b1; IF_addr = 32'h0000_1004;
    tick();
    chk("b2b_ready1", {31'b0, IF_ready}, 32'd1);
    tick();
    chk("b2b_ready2", {31'b0, IF_ready}, 32'd1);
    chk("b2b_inst", IF_inst, 32'hDEAD_BEEF);
    IF_valid = 1'b0;
    tick();
    chk("b2b_end", {31'b0, IF_ready}, 32'd0);

    // A clear two cycles into a miss at 0x2000 fills the line but sends no
    // response.
    req(32'h0000_2000);
    chk("clr_rn", {31'b0, IC_rn}, 32'd1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_rn_held", {31'b0, IC_rn}, 32'd1);
    tick();
    IC_ready = 1'b1; IC_value = 32'hCAFE_F00D;
    tick();
    chk("clr_no_ready", {31'b0, IF_ready}, 32'd0);
    chk("clr_rn_done", {31'b0, IC_rn}, 32'd0);
    IC_ready = 1'b0;
    tick();
    chk("clr_no_ready2", {31'b0, IF_ready}, 32'd0);
    req(32'h0000_2000);
    chk("clr_hit_ready", {31'b0, IF_ready}, 32'd1);
    chk("clr_hit_inst", IF_inst, 32'hCAFE_F00D);
    chk("clr_hit_rn", {31'b0, IC_rn}, 32'd0);

    // In IDLE, clear blocks a miss request and suppresses a hit response.
    IF_valid = 1'b1; IF_addr = 32'h0000_3000; clear = 1'b1;
    tick();
    chk("idle_clr_miss_rn", {31'b0, IC_rn}, 32'd0);
    chk("idle_clr_miss_rdy", {31'b0, IF_ready}, 32'd0);
    IF_addr = 32'h0000_2000;
    tick();
    chk("idle_clr_hit_rdy", {31'b0, IF_ready}, 32'd0);
    IF_valid = 1'b0; clear = 1'b0;

    // With rdy low for 5 cycles in the middle of a miss, the miss holds and
    // then completes once rdy returns.
    req(32'h0000_4000);
    tick();
    rdy = 1'b0; IC_ready = 1'b1; IC_value = 32'h0BAD_F00D;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rdy_rn", {31'b0, IC_rn}, 32'd1);
      chk("rdy_addr", IC_addr, 32'h0000_4000);
      chk("rdy_no_ready", {31'b0, IF_ready}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    chk("rdy_done_ready", {31'b0, IF_ready}, 32'd1);
    chk("rdy_done_inst", IF_inst, 32'h0BAD_F00D);
    IC_ready = 1'b0;
    rdy = 1'b0;
    tick();
    chk("rdy_pulse_frozen", {31'b0, IF_ready}, 32'd1);
    rdy = 1'b1;
    tick();
    chk("rdy_pulse_end", {31'b0, IF_ready}, 32'd0);

    // Reset in the middle of a miss aborts it with no fill.
    req(32'h0000_5000);
    tick();
    rst = 1'b1; IC_ready = 1'b1; IC_value = 32'h5555_5555;
    tick();
    rst = 1'b0; IC_ready = 1'b0;
    chk("rstm_rn", {31'b0, IC_rn}, 32'd0);
    chk("rstm_ready", {31'b0, IF_ready}, 32'd0);
    chk("rstm_addr", IC_addr, 32'h0);
    req(32'h0000_5000);
    chk("rstm_remiss_rn", {31'b0, IC_rn}, 32'd1);
    chk("rstm_remiss_addr", IC_addr, 32'h0000_5000);
    chk("rstm_remiss_rdy", {31'b0, IF_ready}, 32'd0);
    tick();
    IC_ready = 1'b1; IC_value = 32'h6666_7777;
    tick();
    chk("rstm_fill_ready", {31'b0, IF_ready}, 32'd1);
    chk("rstm_fill_inst", IF_inst, 32'h6666_7777);
    IC_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetcher and the memory controller.
- Serves 32-bit instruction words to the fetcher.
- On a miss, issues a single-word read to the memory controller's IC port, fills the line, and returns the word.
- One word per line, matching the memory controller's 32-bit IC transfer.

Parameters:
- INDEX_BITS, 6, number of index bits; the cache holds 2^INDEX_BITS lines of one 32-bit word each.
- ADDR_W, 32, address width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- rdy  input  1  global ready; when low, all state and outputs freeze
- IF_valid  input  1  fetcher requests a word
- IF_addr  input  32  fetch byte address; bits [1:0] ignored
- clear  input  1  flush in-flight fetch (branch mispredict); cache contents kept
- IF_ready  output  1  one-cycle pulse: IF_inst is valid for the last accepted request
- IF_inst  output  32  returned instruction word
- IC_rn  output  1  read request to memory controller
- IC_addr  output  32  word-aligned read address (bits [1:0] = 0)
- IC_ready  input  1  memory controller done; level, may stay high after completion
- IC_value  input  32  word from memory controller, valid while IC_ready is high

Behaviour:
- Address split: offset = addr[1:0] (ignored); index = addr[INDEX_BITS+1:2]; tag = addr[31:INDEX_BITS+2].
- Storage per line: valid bit, tag, data word.
- Reset (rst high at posedge): clear all valid bits; state = IDLE; IF_ready=0, IF_inst=0, IC_rn=0, IC_addr=0; clear the drop flag and the stale-ready flag. Reset aborts any in-progress miss with no fill.
- rdy low: no register changes, including array writes; outputs hold their values.
- States:
  - IDLE: accepts a request when IF_valid=1 and clear=0. Latches the aligned address.
    - Hit (valid && tag match): next cycle IF_ready=1, IF_inst=line data; stay IDLE.
    - Miss: go to MISS; next cycle IC_rn=1, IC_addr=latched aligned address, IF_ready=0.
  - MISS: IC_rn and IC_addr held constant.
    - Stale-ready guard: IC_ready is accepted only after IC_ready has been sampled low at least once since entering MISS.
    - On the accepting edge: write line (valid=1, tag, IC_value); IC_rn<=0; IF_inst<=IC_value; IF_ready<=1 unless the drop flag is set; clear the drop flag; go to IDLE.
- Latency:
  - Hit: IF_ready one cycle after acceptance. Back-to-back hits sustain 1 word/cycle, because a new request is accepted in the same cycle IF_ready is high.
  - Miss: IF_ready one cycle after the accepted IC_ready edge.
- IF_ready is high for exactly one cycle per delivered response. IF_inst holds its value until the next response.
- The fetcher may change IF_addr after acceptance; the cache uses only the latched address.
- clear:
  - In IDLE, clear blocks acceptance that cycle and suppresses any hit response scheduled for the next cycle (IF_ready<=0).
  - In MISS, set the drop flag. The memory read completes and the line is filled, but no IF_ready is issued.
  - clear does not invalidate lines.
- Simultaneous clear and IF_valid in IDLE: the request is not accepted.
- Simultaneous clear and accepted IC_ready in MISS: fill the line; no IF_ready.
- Index aliasing: a fill overwrites the line unconditionally (last fill wins).
- No write port; self-modifying code is not supported.

Test Plan:
- Cold miss:
  - Stimulus: after reset, IF_valid=1, IF_addr=0x0000_1004. Model returns IC_ready after 6 cycles with IC_value=0xDEAD_BEEF.
  - Required: IC_rn=1 with IC_addr=0x1004 until the accepted IC_ready; one-cycle IF_ready with IF_inst=0xDEAD_BEEF; IC_rn=0 afterward.
- Hit after fill:
  - Stimulus: re-request 0x1006.
  - Required: IF_ready the next cycle with 0xDEAD_BEEF; IC_rn stays 0.
- Conflict:
  - Stimulus: request 0x0000_1104 (same index 1, different tag).
  - Required: miss; IC_addr=0x1104; the new value is returned. A subsequent request to 0x1004 misses again.
- Stale ready:
  - Stimulus: model holds IC_ready=1 continuously from the previous fill into a new miss, drops it 1 cycle, then raises it with 0x1234_5678.
  - Required: only 0x1234_5678 is delivered.
- Clear during miss:
  - Stimulus: assert clear 2 cycles into a miss at 0x2000; then request 0x2000.
  - Required: no IF_ready for the first request; the later request hits immediately.
- rdy/reset:
  - Stimulus: rdy=0 for 5 cycles mid-miss.
  - Required: IC_rn/IC_addr held; completion proceeds after rdy=1.
  - Stimulus: rst mid-miss.
  - Required: IC_rn=0; the next request to the same address misses.
